pwm_cfg_arbiter: RTL
====================

Name: pwm_cfg_arbiter

Overview:
Arbitrates and commits configuration writes to the PWM/output-enable register bank from two requesters:
- Port A: the SPI peripheral's decoded write path.
- Port B: an on-chip sequencer.

Round-robin grant, one staged write per cycle. Duty-cycle updates are deferred to the PWM period boundary to avoid glitched pulses. The five register outputs drive the PWM generator and output-enable muxes directly.

Parameters:
- NUM_REGS, 5, number of implemented register addresses (0..NUM_REGS-1).
- ADDR_W, 7, request address width.
- DATA_W, 8, register/data width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- a_valid  in  1  port A write request
- a_ready  out  1  port A grant; handshake when a_valid & a_ready
- a_addr  in  ADDR_W  port A register address
- a_data  in  DATA_W  port A write data
- b_valid  in  1  port B write request
- b_ready  out  1  port B grant
- b_addr  in  ADDR_W  port B register address
- b_data  in  DATA_W  port B write data
- pwm_period_end  in  1  single-cycle strobe from PWM counter at period wrap
- en_reg_out_7_0  out  8  register 0x00
- en_reg_out_15_8  out  8  register 0x01
- en_reg_pwm_7_0  out  8  register 0x02
- en_reg_pwm_15_8  out  8  register 0x03
- pwm_duty_cycle  out  8  register 0x04 (active value)
- duty_pending  out  1  a deferred duty value awaits the next period end
- err_addr  out  1  one-cycle pulse: accepted write had addr >= NUM_REGS
- last_grant  out  1  0 = A, 1 = B; port granted most recently

Behaviour:
Reset:
- Reset is asynchronous, active-high on rst, single clock clk.
- While rst is high: all register outputs 0, duty shadow 0, duty_pending 0, err_addr 0, stage empty, last_grant 1 (so A wins first contention).
- Reset mid-transaction discards the staged write and any pending duty.

Arbitration (combinational from valids and last_grant):
- Only one valid: that port is ready.
- Both valid: grant the port not equal to last_grant.
- Neither valid: both ready low.
- At most one handshake per cycle. last_grant updates on each handshake.
- Requesters must not make valid depend on ready. Valid, addr and data hold until handshake.
- Never both ready in the same cycle.

Pipeline:
- Handshake at edge N loads the stage register {addr, data}, valid.
- Stage commits at edge N+1; the register output is visible after edge N+1 (2-cycle latency from request-cycle start).
- Stage drains every cycle, so sustained throughput is 1 write/cycle.
- Back-to-back writes to the same address: last wins, in grant order.

Commit decode:
- addr 0..3: write the corresponding output register.
- addr 4: write duty shadow and set duty_pending.
- addr >= NUM_REGS: no register change; err_addr high for exactly the commit cycle.

Duty FSM, states IDLE and PENDING:
- IDLE -> PENDING on an addr-4 commit.
- PENDING -> IDLE on pwm_period_end: pwm_duty_cycle <= shadow, duty_pending <= 0.
- Addr-4 commit while PENDING: overwrite shadow, stay PENDING.
- Addr-4 commit and pwm_period_end in the same cycle:
  - The old shadow is applied to pwm_duty_cycle.
  - The new data goes to the shadow.
  - State stays PENDING.
- pwm_period_end in IDLE: no effect.

Optional Feature:
PWM_DUTY_SYNC_EN
- Defined: duty writes are deferred via the duty FSM as above.
- Undefined: addr-4 commits write pwm_duty_cycle directly at commit, same latency as regs 0..3. duty_pending is tied 0, pwm_period_end is ignored, and the FSM and shadow are removed.

Test Plan:
- Reset: rst high mid-write with duty pending -> all outputs 0, duty_pending 0, stage write lost; first post-reset write behaves normally.
- A-only write addr 0x02 data 0xA5 -> a_ready same cycle; en_reg_pwm_7_0 = 0xA5 two cycles later; other regs unchanged.
- Contention: A and B both valid continuously, A addr 0x00 data 0x11, B addr 0x00 data 0x22 -> grants alternate A, B, A, B starting with A. en_reg_out_7_0 toggles 0x11/0x22 each cycle; last_grant alternates.
- Duty defer (macro on): write addr 0x04 = 0x80, then 0x40 before the boundary -> pwm_duty_cycle stays at the old value and duty_pending = 1. At pwm_period_end it becomes 0x40, duty_pending drops.
- Simultaneous: pending 0x40, then an addr-4 write of 0x10 commits in the pwm_period_end cycle -> duty = 0x40, duty_pending stays 1. At the next period end, duty = 0x10.
- Bad address: B writes addr 0x05 data 0xFF -> b_ready handshake, err_addr pulses 1 cycle at commit, no register changes. Macro off: an addr-4 write updates pwm_duty_cycle immediately.

Source files
------------

// File: rtl/pwm_cfg_arbiter_if.sv
// Write-request bundle for the two configuration requesters (A: SPI decode, B: sequencer).
// master = requester side, slave = arbiter side.
interface pwm_cfg_arbiter_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/pwm_cfg_arbiter.sv
// Round-robin arbiter committing config writes to the PWM / output-enable register bank.
// Define PWM_DUTY_SYNC_EN to defer duty-cycle writes to the next PWM period boundary.
module pwm_cfg_arbiter #(
  parameter int unsigned NUM_REGS = 5,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  pwm_cfg_arbiter_if.slave  bus,
  input  logic              pwm_period_end,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              duty_pending,
  output logic              err_addr,
  output logic              last_grant
);

  localparam logic [ADDR_W-1:0] AddrOutLo = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrOutHi = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrPwmLo = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] AddrPwmHi = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] AddrDuty  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] NumRegsA  = ADDR_W'(NUM_REGS);

  logic              grant_a, grant_b;
  logic              last_grant_q;
  logic              stage_valid_q;
  logic [ADDR_W-1:0] stage_addr_q;
  logic [DATA_W-1:0] stage_data_q;
  logic [DATA_W-1:0] reg_out_lo_q, reg_out_hi_q, reg_pwm_lo_q, reg_pwm_hi_q, duty_q;
  logic              err_addr_q;
  logic              duty_wr;

  // Contention goes to the port that did not win last; at most one grant per cycle.
  always_comb begin
    grant_a = bus.a_valid & (~bus.b_valid | last_grant_q);
    grant_b = bus.b_valid & (~bus.a_valid | ~last_grant_q);
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  assign duty_wr = stage_valid_q && (stage_addr_q == AddrDuty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q  <= 1'b1;
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
      reg_out_lo_q  <= '0;
      reg_out_hi_q  <= '0;
      reg_pwm_lo_q  <= '0;
      reg_pwm_hi_q  <= '0;
      err_addr_q    <= 1'b0;
    end else begin
      stage_valid_q <= grant_a | grant_b;
      if (grant_a) begin
        last_grant_q <= 1'b0;
        stage_addr_q <= bus.a_addr;
        stage_data_q <= bus.a_data;
      end else if (grant_b) begin
        last_grant_q <= 1'b1;
        stage_addr_q <= bus.b_addr;
        stage_data_q <= bus.b_data;
      end

      if (stage_valid_q) begin
        case (stage_addr_q)
          AddrOutLo: reg_out_lo_q <= stage_data_q;
          AddrOutHi: reg_out_hi_q <= stage_data_q;
          AddrPwmLo: reg_pwm_lo_q <= stage_data_q;
          AddrPwmHi: reg_pwm_hi_q <= stage_data_q;
          default:   ;
        endcase
      end
      err_addr_q <= stage_valid_q && (stage_addr_q >= NumRegsA);
    end
  end

`ifdef PWM_DUTY_SYNC_EN
  typedef enum logic [0:0] {StIdle, StPending} duty_st_e;

  duty_st_e          duty_st_q;
  logic [DATA_W-1:0] duty_shadow_q;
  logic              duty_pending_q;

  // A boundary applies the old shadow even when a new duty commits in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_st_q      <= StIdle;
      duty_shadow_q  <= '0;
      duty_q         <= '0;
      duty_pending_q <= 1'b0;
    end else begin
      if (pwm_period_end && (duty_st_q == StPending)) begin
        duty_q <= duty_shadow_q;
      end
      if (duty_wr) begin
        duty_shadow_q  <= stage_data_q;
        duty_st_q      <= StPending;
        duty_pending_q <= 1'b1;
      end else if (pwm_period_end && (duty_st_q == StPending)) begin
        duty_st_q      <= StIdle;
        duty_pending_q <= 1'b0;
      end
    end
  end

  assign duty_pending = duty_pending_q;
`else
  logic unused_period_end;
  assign unused_period_end = pwm_period_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
    end else if (duty_wr) begin
      duty_q <= stage_data_q;
    end
  end

  assign duty_pending = 1'b0;
`endif

  assign en_reg_out_7_0  = reg_out_lo_q;
  assign en_reg_out_15_8 = reg_out_hi_q;
  assign en_reg_pwm_7_0  = reg_pwm_lo_q;
  assign en_reg_pwm_15_8 = reg_pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign err_addr        = err_addr_q;
  assign last_grant      = last_grant_q;

endmodule
